instr_fetch_decoder: RTL

Byte-stream instruction assembler and decode queue for the z8 core. It accepts a stream of instruction bytes (opcode, then 0-2 operands) through a valid/ready handshake and looks up each opcode's operand count in the instruction_set package (OPCODES enum). Each complete instruction is pushed into a parametrised first-word-fall-through queue for the execute stage. It is the width- and depth-generalised successor of the fixed 8-bit opcode list, adding illegal-opcode detection, buffering and flush.

---
 rtl/instr_fetch_decoder.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_decoder.sv
//------------------------------------------------------------------------------
// Module   : instr_fetch_decoder (with package instruction_set)
// Purpose  : Assembles z8 instruction bytes into decoded entries and buffers
//            them in a first-word-fall-through queue for the execute stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package instruction_set;

  typedef enum logic [7:0] {
    NOP   = 8'h00,
    LDD   = 8'h01,
    LDD_I = 8'h02,
    LDR   = 8'h03,
    STR   = 8'h04,
    STR_I = 8'h05,
    MOV   = 8'h06,
    ADD   = 8'h07,
    SUB   = 8'h08,
    ANDR  = 8'h09,
    INC   = 8'h0A,
    DEC   = 8'h0B,
    ORR   = 8'h0C,
    XORR  = 8'h0D,
    NEG   = 8'h0E,
    SHL   = 8'h0F,
    SHR   = 8'h10,
    CMP   = 8'h11,
    PUSH  = 8'h12,
    POP   = 8'h13,
    JMP   = 8'h14,
    JZ    = 8'h15,
    JNZ   = 8'h16,
    CALL  = 8'h17,
    RETI  = 8'h18,
    OUTP  = 8'h19,
    SB    = 8'h1A,
    CB    = 8'h1B
  } OPCODES;

  // First opcode value with no defined instruction.
  localparam logic [7:0] ILLEGAL_BASE = 8'h1C;

  function automatic logic [1:0] op_len(input logic [7:0] opc);
    if (opc == NOP)
      return 2'd0;
    else if ((opc >= LDD && opc <= STR_I) || opc == SB || opc == CB)
      return 2'd2;
    else
      return 2'd1;
  endfunction

endpackage

module instr_fetch_decoder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_opcode,
  output logic [DATA_W-1:0]            out_op_a,
  output logic [DATA_W-1:0]            out_op_b,
  output logic [1:0]                   out_len,
  output logic                         out_illegal,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  import instruction_set::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [7:0]        opcode;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [1:0]        len;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {
    S_OPC = 2'd0,
    S_OPA = 2'd1,
    S_OPB = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [1:0]        len_q, len_d;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_hi_nz;
  logic              w_illegal;
  logic [7:0]        w_opc;
  entry_t            w_push_entry;
  entry_t            w_head;

  assign in_ready  = !rst && !flush && (count_q < CNT_W'(DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (count_q != '0);
  assign w_pop     = out_valid && out_ready && !flush;
  assign busy      = (state_q != S_OPC);
  assign q_count   = count_q;
  assign w_opc     = in_data[7:0];

  generate
    if (DATA_W > 8) begin : g_wide
      assign w_hi_nz = |in_data[DATA_W-1:8];
    end else begin : g_narrow
      assign w_hi_nz = 1'b0;
    end
  endgenerate

  assign w_illegal = (w_opc >= ILLEGAL_BASE) || w_hi_nz;

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    op_a_d       = op_a_q;
    len_d        = len_q;
    w_push       = 1'b0;
    w_push_entry = '0;
    if (flush) begin
      state_d  = S_OPC;
      opcode_d = '0;
      op_a_d   = '0;
      len_d    = '0;
    end else if (w_accept) begin
      case (state_q)
        S_OPC: begin
          if (w_illegal) begin
            // Illegal bytes go straight to the queue; no resynchronisation.
            w_push               = 1'b1;
            w_push_entry.opcode  = w_opc;
            w_push_entry.illegal = 1'b1;
          end else begin
            opcode_d = w_opc;
            len_d    = op_len(w_opc);
            if (op_len(w_opc) == 2'd0) begin
              w_push              = 1'b1;
              w_push_entry.opcode = w_opc;
            end else begin
              state_d = S_OPA;
            end
          end
        end
        S_OPA: begin
          op_a_d = in_data;
          if (len_q == 2'd1) begin
            w_push              = 1'b1;
            w_push_entry.opcode = opcode_q;
            w_push_entry.op_a   = in_data;
            w_push_entry.len    = 2'd1;
            state_d             = S_OPC;
          end else begin
            state_d = S_OPB;
          end
        end
        S_OPB: begin
          w_push              = 1'b1;
          w_push_entry.opcode = opcode_q;
          w_push_entry.op_a   = op_a_q;
          w_push_entry.op_b   = in_data;
          w_push_entry.len    = 2'd2;
          state_d             = S_OPC;
        end
        default: state_d = S_OPC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OPC;
      opcode_q <= '0;
      op_a_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_a_q   <= op_a_d;
      len_q    <= len_d;
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push)
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (w_pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push)
      mem_q[wr_ptr_q] <= w_push_entry;
  end

  assign w_head      = mem_q[rd_ptr_q];
  assign out_opcode  = out_valid ? w_head.opcode  : '0;
  assign out_op_a    = out_valid ? w_head.op_a    : '0;
  assign out_op_b    = out_valid ? w_head.op_b    : '0;
  assign out_len     = out_valid ? w_head.len     : '0;
  assign out_illegal = out_valid ? w_head.illegal : 1'b0;

endmodule

`default_nettype wire
